// File: rtl/mem_bus_if.sv
// Bridges the instruction decoder's single-access memory requests onto a
// req/ack external bus, with a timeout abort and a read/write conflict error.
module mem_bus_if #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_mem_rd,
   input  logic        i_mem_wr,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_wdata,
   output logic        o_stall,
   output logic [15:0] o_rdata,
   output logic        o_rdata_valid,
   output logic        o_err,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [15:0] o_bus_addr,
   output logic [15:0] o_bus_wdata,
   input  logic        i_bus_ack,
   input  logic [15:0] i_bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        bus_req_reg, bus_req_next;
   logic        bus_we_reg, bus_we_next;
   logic [15:0] bus_addr_reg, bus_addr_next;
   logic [15:0] bus_wdata_reg, bus_wdata_next;
   logic [15:0] rdata_reg, rdata_next;
   logic        rdata_valid_reg, rdata_valid_next;
   logic        err_reg, err_next;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath and output registers; every output except o_stall is registered
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_reg         <= 8'd0;
         bus_req_reg     <= 1'b0;
         bus_we_reg      <= 1'b0;
         bus_addr_reg    <= 16'd0;
         bus_wdata_reg   <= 16'd0;
         rdata_reg       <= 16'd0;
         rdata_valid_reg <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         cnt_reg         <= cnt_next;
         bus_req_reg     <= bus_req_next;
         bus_we_reg      <= bus_we_next;
         bus_addr_reg    <= bus_addr_next;
         bus_wdata_reg   <= bus_wdata_next;
         rdata_reg       <= rdata_next;
         rdata_valid_reg <= rdata_valid_next;
         err_reg         <= err_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      bus_req_next     = bus_req_reg;
      bus_we_next      = bus_we_reg;
      bus_addr_next    = bus_addr_reg;
      bus_wdata_next   = bus_wdata_reg;
      rdata_next       = rdata_reg;
      rdata_valid_next = 1'b0;
      err_next         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (i_mem_rd ^ i_mem_wr) begin
               state_next     = WAIT;
               cnt_next       = 8'd1;
               bus_req_next   = 1'b1;
               bus_we_next    = i_mem_wr;
               bus_addr_next  = i_addr;
               bus_wdata_next = i_wdata;
            end else if (i_mem_rd && i_mem_wr) begin
               state_next = DONE;
               err_next   = 1'b1;
            end
         end

         WAIT: begin
            // Ack is tested before the timeout so a same-cycle ack completes normally
            if (i_bus_ack) begin
               state_next   = DONE;
               cnt_next     = 8'd0;
               bus_req_next = 1'b0;
               if (!bus_we_reg) begin
                  rdata_next       = i_bus_rdata;
                  rdata_valid_next = 1'b1;
               end
            end else if (cnt_reg == TIMEOUT_CNT) begin
               state_next   = DONE;
               cnt_next     = 8'd0;
               bus_req_next = 1'b0;
               err_next     = 1'b1;
               if (!bus_we_reg) begin
                  rdata_next       = ERR_DATA;
                  rdata_valid_next = 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end

         DONE: begin
            state_next = IDLE;
            cnt_next   = 8'd0;
         end

         default: begin
            state_next   = IDLE;
            cnt_next     = 8'd0;
            bus_req_next = 1'b0;
         end
      endcase
   end

   // Stall covers the request cycle and all of WAIT; DONE releases the decoder
   always_comb begin
      o_stall = 1'b0;
      case (state_reg)
         IDLE:    o_stall = i_mem_rd | i_mem_wr;
         WAIT:    o_stall = 1'b1;
         default: o_stall = 1'b0;
      endcase
   end

   assign o_rdata       = rdata_reg;
   assign o_rdata_valid = rdata_valid_reg;
   assign o_err         = err_reg;
   assign o_bus_req     = bus_req_reg;
   assign o_bus_we      = bus_we_reg;
   assign o_bus_addr    = bus_addr_reg;
   assign o_bus_wdata   = bus_wdata_reg;

endmodule

// File: tb/tb_mem_bus_if.sv
// Scoreboard bench for mem_bus_if: stimulus queues expected rdata_valid/err
// pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_bus_if;

   localparam int TO = 16;

   logic        clk;
   logic        rst_n;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        stall;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        err;
   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic        bus_ack;
   logic [15:0] bus_rdata;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [15:0] data;
   } resp_t;

   resp_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   mem_bus_if #(
      .TIMEOUT  (TO),
      .ERR_DATA (16'hFFFF)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_mem_rd      (mem_rd),
      .i_mem_wr      (mem_wr),
      .i_addr        (addr),
      .i_wdata       (wdata),
      .o_stall       (stall),
      .o_rdata       (rdata),
      .o_rdata_valid (rdata_valid),
      .o_err         (err),
      .o_bus_req     (bus_req),
      .o_bus_we      (bus_we),
      .o_bus_addr    (bus_addr),
      .o_bus_wdata   (bus_wdata),
      .i_bus_ack     (bus_ack),
      .i_bus_rdata   (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rdata_valid/err pulse must match the head of the queue
   always @(negedge clk) begin
      if (rst_n && (rdata_valid || err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got valid=%b err=%b rdata=%h expected none",
                     rdata_valid, err, rdata);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("resp_valid", {31'd0, rdata_valid}, {31'd0, e.valid});
            check("resp_err", {31'd0, err}, {31'd0, e.err});
            check("resp_rdata", {16'd0, rdata}, {16'd0, e.data});
            $display("resp valid=%b err=%b rdata=%h", rdata_valid, err, rdata);
         end
      end
   end

   // One bus access: ack_at = WAIT cycle carrying the ack (0 = never acked)
   task automatic bus_access(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] wd, input int ack_at, input logic [15:0] ack_data,
                             input logic ev, input logic ee, input logic [15:0] exp_rdata);
      int cycles;
      int exp_cycles;
      resp_t r;
      exp_cycles = (ack_at > 0) ? ack_at : TO;
      @(negedge clk);
      mem_rd = rd;
      mem_wr = wr;
      addr   = a;
      wdata  = wd;
      if (ev || ee) begin
         r.valid = ev;
         r.err   = ee;
         r.data  = exp_rdata;
         exp_q.push_back(r);
      end
      #1;
      check("stall_idle_req", {31'd0, stall}, 32'd1);
      @(posedge clk);
      cycles = 0;
      forever begin
         @(negedge clk);
         if (!bus_req) break;
         cycles++;
         check("bus_we", {31'd0, bus_we}, {31'd0, wr});
         check("bus_addr", {16'd0, bus_addr}, {16'd0, a});
         if (wr) check("bus_wdata", {16'd0, bus_wdata}, {16'd0, wd});
         check("stall_wait", {31'd0, stall}, 32'd1);
         if (cycles == ack_at) begin
            bus_ack   = 1'b1;
            bus_rdata = ack_data;
         end else begin
            bus_ack   = 1'b0;
            bus_rdata = 16'h0000;
         end
         if (cycles > TO + 2) begin
            checks++;
            failures++;
            $display("FAIL wait_bound: got %0d req cycles expected %0d", cycles, exp_cycles);
            break;
         end
      end
      bus_ack = 1'b0;
      check("req_cycles", cycles, exp_cycles);
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      #1;
      check("stall_done", {31'd0, stall}, 32'd0);
      @(negedge clk);
      check("rdata_after", {16'd0, rdata}, {16'd0, exp_rdata});
      $display("txn rd=%b wr=%b addr=%h wdata=%h req_cycles=%0d rdata=%h",
               rd, wr, a, wd, cycles, rdata);
   endtask

   initial begin
      resp_t r;
      int cycles;
      rst_n     = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      addr      = 16'h0000;
      wdata     = 16'h0000;
      bus_ack   = 1'b0;
      bus_rdata = 16'h0000;
      #12;
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_rdata", {16'd0, rdata}, 32'd0);
      check("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
      check("rst_err_valid", {30'd0, err, rdata_valid}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      $display("txn reset released");

      // Read, minimum latency
      bus_access(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF);
      // Write acked after 5 WAIT cycles; rdata keeps BEEF
      bus_access(1'b0, 1'b1, 16'h0200, 16'h1234, 5, 16'h7777, 1'b0, 1'b0, 16'hBEEF);
      // Read timeout
      bus_access(1'b1, 1'b0, 16'h0300, 16'h0000, 0, 16'h0000, 1'b1, 1'b1, 16'hFFFF);

      // Conflict: rd and wr together
      @(negedge clk);
      mem_rd = 1'b1;
      mem_wr = 1'b1;
      r.valid = 1'b0;
      r.err   = 1'b1;
      r.data  = 16'hFFFF;
      exp_q.push_back(r);
      #1;
      check("conf_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      check("conf_bus_req", {31'd0, bus_req}, 32'd0);
      check("conf_stall_done", {31'd0, stall}, 32'd0);
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      @(negedge clk);
      check("conf_idle_req", {31'd0, bus_req}, 32'd0);
      $display("txn conflict rdata=%h", rdata);

      // Spurious ack in IDLE
      @(negedge clk);
      bus_ack   = 1'b1;
      bus_rdata = 16'h1111;
      @(negedge clk);
      bus_ack = 1'b0;
      check("spur_rdata", {16'd0, rdata}, 32'h0000FFFF);
      check("spur_bus_req", {31'd0, bus_req}, 32'd0);
      $display("txn spurious ack rdata=%h", rdata);
      // Ack exactly on the timeout cycle wins
      bus_access(1'b1, 1'b0, 16'h0400, 16'h0000, TO, 16'h5A5A, 1'b1, 1'b0, 16'h5A5A);
      // Write timeout: err only, rdata untouched
      bus_access(1'b0, 1'b1, 16'h0500, 16'h0F0F, 0, 16'h0000, 1'b0, 1'b1, 16'h5A5A);

      // Reset asserted in the 3rd WAIT cycle
      @(negedge clk);
      mem_rd = 1'b1;
      addr   = 16'h0600;
      @(posedge clk);
      cycles = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus_req) cycles++;
      end
      check("rst_wait_cycles", cycles, 3);
      rst_n  = 1'b0;
      mem_rd = 1'b0;
      #1;
      check("arst_bus_req", {31'd0, bus_req}, 32'd0);
      check("arst_bus_addr", {16'd0, bus_addr}, 32'd0);
      check("arst_rdata", {16'd0, rdata}, 32'd0);
      check("arst_err_valid", {30'd0, err, rdata_valid}, 32'd0);
      check("arst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("txn reset during wait");
      bus_access(1'b1, 1'b0, 16'h0700, 16'h0000, 2, 16'hC3C3, 1'b1, 1'b0, 16'hC3C3);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
